updown_mod_counter: RTL and testbench

Parametrised synchronous up/down modulo-N counter with enable, synchronous clear, parallel load, wrap or saturate mode, and a cascade carry output. It is the general counting primitive for the vending-machine datapath: coin/credit tallies, item-slot indices and timeout dividers. Instances can be chained through `tc` to build wider counters.

---
 rtl/updown_mod_counter.sv | 80 ++++++++
 tb/tb_updown_mod_counter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// Up/down modulo-MODULUS counter with clear, clamped parallel load, wrap or
// saturate at the boundaries, and a combinational cascade carry (tc).
module updown_mod_counter #(
  parameter int WIDTH    = 3,
  parameter int MODULUS  = 6,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             at_max,
  output logic             at_min,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MAX_W = (WIDTH + 1)'(MODULUS - 1);
  localparam logic [WIDTH:0]   ONE_W = (WIDTH + 1)'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   inc, dec;
  logic             top_hit, bottom_hit;

  // One extra bit makes both boundaries plain flags: the increment passes MAX,
  // or the decrement borrows out of zero.
  assign inc        = {1'b0, cnt_q} + ONE_W;
  assign dec        = {1'b0, cnt_q} - ONE_W;
  assign top_hit    = (inc > MAX_W);
  assign bottom_hit = dec[WIDTH];

  assign q      = cnt_q;
  assign ovf    = ovf_q;
  assign at_max = (cnt_q == MAX);
  assign at_min = (cnt_q == '0);
  assign tc     = en & ~clr & ~load & ((up & at_max) | (~up & at_min));

  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = ({1'b0, load_val} > MAX_W) ? MAX : load_val;
    end else if (en && up) begin
      if (top_hit) begin
        ovf_d = 1'b1;
        cnt_d = (SATURATE != 0) ? MAX : '0;
      end else begin
        cnt_d = inc[WIDTH-1:0];
      end
    end else if (en) begin
      if (bottom_hit) begin
        ovf_d = 1'b1;
        cnt_d = (SATURATE != 0) ? '0 : MAX;
      end else begin
        cnt_d = dec[WIDTH-1:0];
      end
    end
  end

  // NOTE: non-blocking assignments for state; blocking here would race other flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor pops
// and compares them on the falling clock edge (or on demand for async reset).
module tb_updown_mod_counter;

  typedef struct packed {
    logic [2:0] dut;
    logic [3:0] q;
    logic       ovf;
    logic       tc;
    logic       amax;
    logic       amin;
  } exp_t;

  logic       clk, rst, clr, load, en, up;
  logic [3:0] lv;

  logic [2:0] q0, q1, q2, q3;
  logic [3:0] q4;
  logic       tc0, tc1, tc2, tc3, tc4;
  logic       mx0, mx1, mx2, mx3, mx4;
  logic       mn0, mn1, mn2, mn3, mn4;
  logic       ov0, ov1, ov2, ov3, ov4;

  exp_t  sb[$];
  string nm_q[$];
  int    total = 0;
  int    bad   = 0;
  event  sample_ev;

  updown_mod_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv[2:0]), .en(en), .up(up),
    .q(q0), .tc(tc0), .at_max(mx0), .at_min(mn0), .ovf(ov0));

  updown_mod_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv[2:0]), .en(en), .up(up),
    .q(q1), .tc(tc1), .at_max(mx1), .at_min(mn1), .ovf(ov1));

  updown_mod_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(0)) u_lo (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv[2:0]), .en(en), .up(up),
    .q(q2), .tc(tc2), .at_max(mx2), .at_min(mn2), .ovf(ov2));

  updown_mod_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(0)) u_hi (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv[2:0]), .en(tc2), .up(up),
    .q(q3), .tc(tc3), .at_max(mx3), .at_min(mn3), .ovf(ov3));

  updown_mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_bin (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv), .en(en), .up(up),
    .q(q4), .tc(tc4), .at_max(mx4), .at_min(mn4), .ovf(ov4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: everything queued so far is compared against the current outputs.
  always begin
    exp_t       e;
    string      nm;
    logic [3:0] gq;
    logic       go, gt, gx, gn;
    @(negedge clk or sample_ev);
    while (sb.size() > 0) begin
      e  = sb.pop_front();
      nm = nm_q.pop_front();
      case (e.dut)
        3'd0:    begin gq = {1'b0, q0}; go = ov0; gt = tc0; gx = mx0; gn = mn0; end
        3'd1:    begin gq = {1'b0, q1}; go = ov1; gt = tc1; gx = mx1; gn = mn1; end
        3'd2:    begin gq = {1'b0, q2}; go = ov2; gt = tc2; gx = mx2; gn = mn2; end
        3'd3:    begin gq = {1'b0, q3}; go = ov3; gt = tc3; gx = mx3; gn = mn3; end
        default: begin gq = q4;         go = ov4; gt = tc4; gx = mx4; gn = mn4; end
      endcase
      total++;
      if (gq !== e.q || go !== e.ovf || gt !== e.tc || gx !== e.amax || gn !== e.amin) begin
        bad++;
        $display("FAIL %s dut%0d: got q=%0d ovf=%b tc=%b at_max=%b at_min=%b, want q=%0d ovf=%b tc=%b at_max=%b at_min=%b",
                 nm, e.dut, gq, go, gt, gx, gn, e.q, e.ovf, e.tc, e.amax, e.amin);
      end
    end
  end

  task automatic expect_v(input int d, input string nm, input int qv,
                          input logic o, input logic t, input logic mx, input logic mn);
    exp_t e;
    e.dut  = 3'(d);
    e.q    = 4'(qv);
    e.ovf  = o;
    e.tc   = t;
    e.amax = mx;
    e.amin = mn;
    sb.push_back(e);
    nm_q.push_back(nm);
  endtask

  // Inputs change just after a falling edge; the following rising edge acts on them.
  task automatic drive(input logic c, input logic l, input logic [3:0] v,
                       input logic e, input logic u);
    @(negedge clk);
    #1;
    clr  = c;
    load = l;
    lv   = v;
    en   = e;
    up   = u;
  endtask

  initial begin
    int wq[7]  = '{1, 2, 3, 4, 5, 0, 1};
    int wov[7] = '{0, 0, 0, 0, 0, 1, 0};
    int sq[5]  = '{4, 5, 5, 5, 5};
    int sov[5] = '{0, 0, 1, 1, 1};
    int lo, hi;

    rst = 1'b0; clr = 1'b0; load = 1'b0; lv = '0; en = 1'b0; up = 1'b0;
    #3;
    for (int d = 0; d < 5; d++) expect_v(d, "reset_state", 0, 0, 0, 0, 1);
    ->sample_ev;
    @(negedge clk); #1; rst = 1'b1;

    // Count 1..4, then assert reset asynchronously in the middle of the high phase.
    for (int k = 1; k <= 4; k++) begin
      drive(0, 0, 0, 1, 1);
      expect_v(0, "count_up", k, 0, 0, 0, 0);
    end
    @(posedge clk); #2;
    ->sample_ev;
    #1; rst = 1'b0; #1;
    expect_v(0, "async_reset", 0, 0, 0, 0, 1);
    ->sample_ev;
    @(negedge clk); #1; rst = 1'b1;
    expect_v(0, "reset_release", 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1); expect_v(0, "count_after_rel", 2, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 1); expect_v(0, "clear_with_en", 0, 0, 0, 0, 1);

    // Wrap up from 0 for 7 edges
    for (int k = 0; k < 7; k++) begin
      drive(0, 0, 0, 1, 1);
      expect_v(0, "wrap_up", wq[k], wov[k][0], wq[k] == 5, wq[k] == 5, wq[k] == 0);
    end

    // Wrap down from 0
    drive(1, 0, 0, 0, 0); expect_v(0, "clr_before_down", 0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 0); expect_v(0, "wrap_down", 5, 1, 0, 1, 0);
    drive(0, 0, 0, 1, 0); expect_v(0, "down_4", 4, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0); expect_v(0, "down_3", 3, 0, 0, 0, 0);

    // Load and priority
    drive(0, 1, 7, 1, 1); expect_v(0, "load_clamp", 5, 0, 0, 1, 0);
    drive(0, 1, 3, 1, 1); expect_v(0, "load_over_en", 3, 0, 0, 0, 0);
    drive(1, 1, 2, 1, 1); expect_v(0, "clr_over_load", 0, 0, 0, 0, 1);
    drive(0, 1, 5, 1, 1); expect_v(0, "load_max", 5, 0, 0, 1, 0);
    drive(0, 1, 4, 1, 1); expect_v(0, "load_kills_ovf", 4, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0); expect_v(0, "hold_en0_a", 4, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1); expect_v(0, "hold_en0_b", 4, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0); expect_v(0, "hold_en0_c", 4, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1); expect_v(0, "dir_up", 5, 0, 1, 1, 0);
    drive(0, 0, 0, 1, 0); expect_v(0, "dir_down", 4, 0, 0, 0, 0);

    // Saturate instance
    drive(0, 1, 3, 0, 0); expect_v(1, "sat_load3", 3, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 1, 1);
      expect_v(1, "sat_up", sq[k], sov[k][0], sq[k] == 5, sq[k] == 5, 0);
    end
    drive(0, 1, 1, 0, 0); expect_v(1, "sat_load1", 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0); expect_v(1, "sat_down_0", 0, 0, 1, 0, 1);
    drive(0, 0, 0, 1, 0); expect_v(1, "sat_down_hold", 0, 1, 1, 0, 1);

    // Full binary range
    drive(0, 1, 15, 0, 0);
    expect_v(4, "bin_load15", 15, 0, 0, 1, 0);
    expect_v(0, "load_clamp_w3", 5, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 1); expect_v(4, "bin_roll_up", 0, 1, 0, 0, 1);
    drive(0, 0, 0, 1, 0); expect_v(4, "bin_roll_down", 15, 1, 0, 1, 0);
    drive(0, 0, 0, 1, 0); expect_v(4, "bin_down_14", 14, 0, 0, 0, 0);

    // Cascade: low stage tc drives high stage en
    drive(1, 0, 0, 0, 1);
    expect_v(2, "casc_clr_lo", 0, 0, 0, 0, 1);
    expect_v(3, "casc_clr_hi", 0, 0, 0, 0, 1);
    for (int k = 1; k <= 36; k++) begin
      drive(0, 0, 0, 1, 1);
      lo = k % 6;
      hi = (k / 6) % 6;
      expect_v(2, "casc_lo", lo, (k % 6) == 0, lo == 5, lo == 5, lo == 0);
      expect_v(3, "casc_hi", hi, k == 36, (lo == 5) && (hi == 5), hi == 5, hi == 0);
    end

    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 8 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

endmodule
